// File: rtl/fact_pkg.sv
// ---------------------------------------------------------------------------
// fact_pkg
// Shared types and constants for the iterative factorial engine.
//   fact_state_t : control FSM states, encoding is also exported on state_dbg
//   MUL_REPADD   : multiplier computes a*b by adding a to itself b times
//   MUL_SHIFTADD : multiplier walks b one bit per cycle, LSB first
// ---------------------------------------------------------------------------
package fact_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      MUL   = 3'd2,
      DONE  = 3'd3
   } fact_state_t;

   localparam int MUL_REPADD   = 0;
   localparam int MUL_SHIFTADD = 1;

endpackage

// File: rtl/fact_engine_if.sv
// ---------------------------------------------------------------------------
// fact_engine_if
// Request/result bundle between the button/control side and the factorial
// engine.
//   start     : request a run (already synchronised upstream)
//   abort     : cancel a run in progress
//   n         : operand, sampled together with start
//   result    : n!, or all-ones when the result does not fit
//   ovf       : result overflowed
//   busy      : engine is not idle
//   done      : single-cycle completion pulse
//   state_dbg : current FSM state encoding
// master : drives the request side (control logic / testbench)
// slave  : the engine itself
// ---------------------------------------------------------------------------
interface fact_engine_if #(
   parameter int N_W = 4,
   parameter int R_W = 16
);

   logic           start;
   logic           abort;
   logic [N_W-1:0] n;
   logic [R_W-1:0] result;
   logic           ovf;
   logic           busy;
   logic           done;
   logic [2:0]     state_dbg;

   modport master (
      output start, abort, n,
      input  result, ovf, busy, done, state_dbg
   );

   modport slave (
      input  start, abort, n,
      output result, ovf, busy, done, state_dbg
   );

endinterface

// File: rtl/fact_mult.sv
// ---------------------------------------------------------------------------
// fact_mult
// Multi-cycle unsigned multiplier used by the factorial engine, p = a * b.
// The accumulator is R_W+N_W bits wide so the full product always fits;
// any set bit above the low R_W bits is reported as mul_ovf.
//   clk, rst  : clock and asynchronous active-high reset
//   clr       : synchronous clear back to idle (used on abort)
//   mul_start : one-cycle pulse that samples a and b
//   a         : multiplicand (running factorial)
//   b         : multiplier (current k)
//   mul_p     : low R_W bits of the product
//   mul_ovf   : product does not fit in R_W bits
//   mul_done  : one-cycle pulse when mul_p / mul_ovf are final
// MUL_MODE selects the algorithm:
//   shift-add    : mul_done N_W cycles after mul_start
//   repeated add : mul_done b cycles after mul_start
// ---------------------------------------------------------------------------
module fact_mult
   import fact_pkg::*;
#(
   parameter int N_W      = 4,
   parameter int R_W      = 16,
   parameter int MUL_MODE = MUL_SHIFTADD
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           mul_start,
   input  logic [R_W-1:0] a,
   input  logic [N_W-1:0] b,
   output logic [R_W-1:0] mul_p,
   output logic           mul_ovf,
   output logic           mul_done
);

   localparam int ACC_W = R_W + N_W;
   localparam int unsigned ONE_I = 1;
   localparam int unsigned STEPS_I = N_W - 1;
   localparam logic [N_W-1:0] CNT_ONE = ONE_I[N_W-1:0];

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] mcand;
   logic [N_W-1:0]   cnt;
   logic             mulDoneReg;

   // Product and overflow are taken straight from the accumulator; they are
   // only meaningful while mul_done is high.
   assign mul_p    = acc[R_W-1:0];
   assign mul_ovf  = |acc[ACC_W-1:R_W];
   assign mul_done = mulDoneReg;

   generate
      if (MUL_MODE == MUL_SHIFTADD) begin : gShiftAdd
         logic [N_W-1:0] mplier;

         // Shift-add: bit 0 of b is consumed in the same edge that accepts
         // the request, the remaining N_W-1 bits follow one per cycle while
         // the multiplicand shifts left. cnt counts the bits still to go.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               acc        <= '0;
               mcand      <= '0;
               mplier     <= '0;
               cnt        <= '0;
               mulDoneReg <= 1'b0;
            end else if (clr) begin
               acc        <= '0;
               mcand      <= '0;
               mplier     <= '0;
               cnt        <= '0;
               mulDoneReg <= 1'b0;
            end else begin
               mulDoneReg <= 1'b0;
               if (mul_start) begin
                  acc        <= b[0] ? {{N_W{1'b0}}, a} : '0;
                  mcand      <= {{N_W{1'b0}}, a} << 1;
                  mplier     <= b >> 1;
                  cnt        <= STEPS_I[N_W-1:0];
                  mulDoneReg <= (N_W == 1);
               end else if (cnt != '0) begin
                  if (mplier[0]) begin
                     acc <= acc + mcand;
                  end
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt - 1'b1;
                  if (cnt == CNT_ONE) begin
                     mulDoneReg <= 1'b1;
                  end
               end
            end
         end
      end else begin : gRepAdd

         // Repeated addition: the first add happens on the accepting edge,
         // the remaining b-1 adds follow one per cycle. A zero multiplier
         // simply reports a zero product on the next cycle.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               acc        <= '0;
               mcand      <= '0;
               cnt        <= '0;
               mulDoneReg <= 1'b0;
            end else if (clr) begin
               acc        <= '0;
               mcand      <= '0;
               cnt        <= '0;
               mulDoneReg <= 1'b0;
            end else begin
               mulDoneReg <= 1'b0;
               if (mul_start) begin
                  mcand <= {{N_W{1'b0}}, a};
                  if (b == '0) begin
                     acc        <= '0;
                     cnt        <= '0;
                     mulDoneReg <= 1'b1;
                  end else begin
                     acc        <= {{N_W{1'b0}}, a};
                     cnt        <= b - 1'b1;
                     mulDoneReg <= (b == CNT_ONE);
                  end
               end else if (cnt != '0) begin
                  acc <= acc + mcand;
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_ONE) begin
                     mulDoneReg <= 1'b1;
                  end
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/fact_engine.sv
// ---------------------------------------------------------------------------
// fact_engine
// Iterative factorial unit: result = n!, computed as n*(n-1)*...*2 with a
// down-counter k and a multi-cycle multiplier. Saturates to all-ones and
// raises ovf as soon as a partial product no longer fits in R_W bits.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : fact_engine_if slave (start/abort/n in; result/ovf/busy/
//              done/state_dbg out)
// All outputs come from registers, so nothing on the request side reaches
// the outputs combinationally.
// ---------------------------------------------------------------------------
module fact_engine
   import fact_pkg::*;
#(
   parameter int N_W      = 4,
   parameter int R_W      = 16,
   parameter int MUL_MODE = MUL_SHIFTADD
) (
   input logic         clk,
   input logic         rst,
   fact_engine_if.slave bus
);

   localparam int unsigned ONE_I = 1;
   localparam logic [N_W-1:0] K_ONE   = ONE_I[N_W-1:0];
   localparam logic [R_W-1:0] RES_ONE = {{(R_W-1){1'b0}}, 1'b1};

   fact_state_t    state;
   logic [N_W-1:0] k;
   logic [R_W-1:0] resultReg;
   logic           ovfReg;
   logic           busyReg;
   logic           doneReg;

   logic           mulStart;
   logic           mulClr;
   logic [R_W-1:0] mulP;
   logic           mulOvf;
   logic           mulDone;

   // The multiplier is kicked from CHECK while there is still a factor
   // above 1 to apply, and flushed whenever a run is aborted so a stale
   // mul_done cannot leak into the next run.
   assign mulStart = (state == CHECK) && !bus.abort && (k > K_ONE);
   assign mulClr   = bus.abort && (state != IDLE);

   fact_mult #(
      .N_W      (N_W),
      .R_W      (R_W),
      .MUL_MODE (MUL_MODE)
   ) uMult (
      .clk       (clk),
      .rst       (rst),
      .clr       (mulClr),
      .mul_start (mulStart),
      .a         (resultReg),
      .b         (k),
      .mul_p     (mulP),
      .mul_ovf   (mulOvf),
      .mul_done  (mulDone)
   );

   // Control FSM with registered busy/done. done is raised on the edge that
   // enters DONE, so it is high for exactly the DONE cycle. Abort beats
   // every other transition outside IDLE; in DONE the pulse already on the
   // output is left alone, only the following state and result change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         resultReg <= '0;
         ovfReg    <= 1'b0;
         busyReg   <= 1'b0;
         doneReg   <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         if ((state != IDLE) && bus.abort) begin
            state     <= IDLE;
            resultReg <= '0;
            ovfReg    <= 1'b0;
            busyReg   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start && !bus.abort) begin
                     state     <= CHECK;
                     k         <= bus.n;
                     resultReg <= RES_ONE;
                     ovfReg    <= 1'b0;
                     busyReg   <= 1'b1;
                  end
               end
               CHECK: begin
                  if (k <= K_ONE) begin
                     state   <= DONE;
                     doneReg <= 1'b1;
                  end else begin
                     state <= MUL;
                  end
               end
               MUL: begin
                  if (mulDone) begin
                     if (mulOvf) begin
                        resultReg <= '1;
                        ovfReg    <= 1'b1;
                        state     <= DONE;
                        doneReg   <= 1'b1;
                     end else begin
                        resultReg <= mulP;
                        k         <= k - 1'b1;
                        state     <= CHECK;
                     end
                  end
               end
               DONE: begin
                  state   <= IDLE;
                  busyReg <= 1'b0;
               end
               default: begin
                  state   <= IDLE;
                  busyReg <= 1'b0;
               end
            endcase
         end
      end
   end

   // Drive the bus straight from the registers.
   assign bus.result    = resultReg;
   assign bus.ovf       = ovfReg;
   assign bus.busy      = busyReg;
   assign bus.done      = doneReg;
   assign bus.state_dbg = state;

endmodule
